// File: rtl/cell_pos_reader.sv
// Cell position reader: fetches the particle count from address 0, then streams particles 1..N as a valid/ready stream.
// Latency: start at edge T -> count read in cycle T+1, count latched at T+3, first out_valid at T+7; 1 particle/cycle after that.
// Backpressure: reads are issued only while in-flight reads plus skid FIFO occupancy leave room, so out_ready low never drops data.
// Optional: define CELL_POS_READER_STALL_CNT_EN to build the stall_cycles counter; otherwise stall_cycles is tied to 0.

// Small synchronous FIFO used as the read-return skid buffer.
module cell_pos_reader_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_dat,
    input  logic                             pop,
    output logic                             vld,
    output logic [WIDTH-1:0]                 dat,
    output logic [$clog2(DEPTH+1)-1:0]       count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Wrap-aware pointer increment so non power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is legal only when the same edge pops an entry.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign vld     = (count != '0);
    assign dat     = store[rd_ptr];

    // Payload storage needs no reset; it is only observed while vld is high.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic [15:0]           stall_cycles
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_CNT   = 3'd1;
    localparam logic [2:0] S_WAIT_CNT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    // Credit arithmetic width: covers in-flight reads plus FIFO occupancy plus one pop credit.
    localparam int CRW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
    localparam int FW  = DATA_WIDTH + ADDR_WIDTH;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Read-return tracking pipe: one slot per cycle of memory latency.
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [ADDR_WIDTH-1:0] pipe_idx [RD_LATENCY];

    logic                  ret_vld;
    logic [ADDR_WIDTH-1:0] ret_idx;
    logic                  fifo_push;
    logic                  cnt_hit;
    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] clamped_count;

    logic                  fifo_vld;
    logic [FW-1:0]         fifo_dat;
    logic [FCW-1:0]        fifo_cnt;
    logic [ADDR_WIDTH-1:0] fifo_idx;
    logic                  pop;

    logic [CRW-1:0]        in_flight;
    logic                  can_issue;

    assign ret_vld = pipe_vld[RD_LATENCY-1];
    assign ret_idx = pipe_idx[RD_LATENCY-1];

    // Address 0 is the count read; every other return is a particle for the FIFO.
    assign fifo_push = ret_vld && (ret_idx != '0);
    assign cnt_hit   = ret_vld && (ret_idx == '0) && (state == S_WAIT_CNT);

    assign raw_count     = mem_q[ADDR_WIDTH-1:0];
    assign clamped_count = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;

    assign mem_wren = 1'b0;
    assign mem_data = '0;

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);

    assign fifo_idx  = fifo_dat[FW-1:DATA_WIDTH];
    assign out_valid = fifo_vld;
    assign out_data  = fifo_vld ? fifo_dat[DATA_WIDTH-1:0] : '0;
    assign out_index = fifo_vld ? fifo_idx : '0;
    assign out_last  = fifo_vld && (fifo_idx == particle_count);
    assign pop       = out_valid && out_ready;

    // Count reads committed but not yet in the FIFO: the one on the memory bus plus the tracking pipe.
    always_comb begin
        in_flight = CRW'(mem_rden);
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CRW'(pipe_vld[i]);
        end
    end

    // A new read may go out if every committed read still has a FIFO slot, counting the entry leaving this edge.
    assign can_issue = (in_flight + CRW'(fifo_cnt)) < (CRW'(FIFO_DEPTH) + CRW'(pop));

    // Shift each issued read toward its return cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= mem_rden;
            pipe_idx[0] <= mem_address;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Scan control: count fetch, credit-limited particle reads, drain, completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mem_rden       <= 1'b0;
            mem_address    <= '0;
            next_addr      <= '0;
            particle_count <= '0;
            count_err      <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RD_CNT;
                        count_err   <= 1'b0;
                        mem_rden    <= 1'b1;
                        mem_address <= '0;
                    end
                end
                S_RD_CNT: begin
                    state <= S_WAIT_CNT;
                end
                S_WAIT_CNT: begin
                    if (cnt_hit) begin
                        particle_count <= clamped_count;
                        count_err      <= (raw_count > MAX_COUNT);
                        if (clamped_count == '0) begin
                            state <= S_FIN;
                        end else begin
                            // The first particle read goes out on the same edge the count lands.
                            mem_rden    <= 1'b1;
                            mem_address <= ADDR_WIDTH'(1);
                            next_addr   <= ADDR_WIDTH'(2);
                            state       <= (clamped_count == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (can_issue) begin
                        mem_rden    <= 1'b1;
                        mem_address <= next_addr;
                        next_addr   <= next_addr + ADDR_WIDTH'(1);
                        if (next_addr == particle_count) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final particle leaving the FIFO means nothing else is outstanding.
                    if (pop && out_last && (in_flight == '0)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    cell_pos_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({ret_idx, mem_q}),
        .pop      (pop),
        .vld      (fifo_vld),
        .dat      (fifo_dat),
        .count    (fifo_cnt)
    );

`ifdef CELL_POS_READER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where the stream is offered but not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule
